// File: rtl/cypher_pkg.sv
// Shared widths and helpers for the cypher-detector datapath.
// Digit count saturates once a full code's worth of digits has been seen.
package cypher_pkg;

  localparam int DIGIT_W  = 4;
  localparam int N_DIGITS = 4;
  localparam int CODE_W   = DIGIT_W * N_DIGITS;
  localparam int SUM_W    = 8;
  localparam int CNT_W    = 3;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_DIGITS);

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt >= CNT_FULL - 1'b1) begin
      return CNT_FULL;
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/digit_shift_matcher.sv
// Holds the last N_DIGITS accepted digits and flags when the digit being
// accepted this cycle completes the cypher.
module digit_shift_matcher
  import cypher_pkg::*;
(
  input  logic               clock,
  input  logic               sl_res,
  input  logic               accept,
  input  logic [DIGIT_W-1:0] num,
  input  logic [CODE_W-1:0]  cypher,
  output logic               match_n
);

  logic [CODE_W-1:0] hist;
  logic [CODE_W-1:0] hist_n;
  logic [CNT_W-1:0]  cnt;
  logic              full_n;

  // Newest digit enters at the top so the first-entered digit lines up with cypher[3:0].
  assign hist_n = {num, hist[CODE_W-1:DIGIT_W]};

  // Without this guard a zero cypher would match the cleared history too early.
  assign full_n  = (cnt >= CNT_FULL - 1'b1);
  assign match_n = accept && full_n && (hist_n == cypher);

  always_ff @(posedge clock) begin
    if (sl_res) begin
      hist <= '0;
      cnt  <= '0;
    end else if (accept) begin
      hist <= hist_n;
      cnt  <= cnt_sat_inc(cnt);
    end
  end

endmodule

// File: rtl/cypher_datapath.sv
// Cypher-detector datapath: running digit sum and sticky stop flag,
// with digit history and code matching in digit_shift_matcher.
module cypher_datapath
  import cypher_pkg::*;
(
  input  logic               clock,
  input  logic               sl_res,
  input  logic               sl_op,
  input  logic [CODE_W-1:0]  cypher,
  input  logic [DIGIT_W-1:0] num,
  output logic               stop,
  output logic [SUM_W-1:0]   sum
);

  logic accept;
  logic match_n;

  // Reset priority is applied inside each register block.
  assign accept = sl_op && !stop;

  digit_shift_matcher u_matcher (
    .clock   (clock),
    .sl_res  (sl_res),
    .accept  (accept),
    .num     (num),
    .cypher  (cypher),
    .match_n (match_n)
  );

  always_ff @(posedge clock) begin
    if (sl_res) begin
      sum  <= '0;
      stop <= 1'b0;
    end else if (accept) begin
      sum <= sum + SUM_W'(num);
      if (match_n) begin
        stop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cypher_datapath.sv
// Self-checking bench for cypher_datapath: directed vector table, hand
// sequences for hold/wrap corners, and randomized sessions against a queue model.
module tb_cypher_datapath;

  logic        clock;
  logic        sl_res;
  logic        sl_op;
  logic [15:0] cypher;
  logic [3:0]  num;
  logic        stop;
  logic [7:0]  sum;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: the accepted digits themselves, oldest first.
  int unsigned m_digits[$];
  int unsigned m_sum;
  bit          m_stop;

  typedef struct {
    logic        res;
    logic        op;
    logic [3:0]  num;
    logic [15:0] cy;
    logic        exp_stop;
    logic [7:0]  exp_sum;
    string       name;
  } vec_t;

  vec_t vecs[$];

  cypher_datapath dut (
    .clock  (clock),
    .sl_res (sl_res),
    .sl_op  (sl_op),
    .cypher (cypher),
    .num    (num),
    .stop   (stop),
    .sum    (sum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic r, input logic op, input logic [3:0] n,
                              input logic [15:0] cy, input logic es, input logic [7:0] esum,
                              input string name);
    vec_t v;
    v.res = r; v.op = op; v.num = n; v.cy = cy;
    v.exp_stop = es; v.exp_sum = esum; v.name = name;
    vecs.push_back(v);
  endfunction

  function automatic bit model_match(input logic [15:0] cy);
    if (m_digits.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (m_digits[i] != ((int'(cy) >> (4 * i)) & 15)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void model_edge(input logic r, input logic op, input logic [3:0] n,
                                     input logic [15:0] cy);
    if (r) begin
      m_digits.delete();
      m_sum  = 0;
      m_stop = 1'b0;
    end else if (op && !m_stop) begin
      m_digits.push_back(int'(n));
      if (m_digits.size() > 4) void'(m_digits.pop_front());
      m_sum = (m_sum + int'(n)) % 256;
      if (model_match(cy)) m_stop = 1'b1;
    end
  endfunction

  task automatic check(input string name, input logic exp_stop, input logic [7:0] exp_sum);
    tests_run++;
    if (stop !== exp_stop || sum !== exp_sum) begin
      tests_failed++;
      $display("FAIL %s: got stop=%0b sum=0x%02h, expected stop=%0b sum=0x%02h",
               name, stop, sum, exp_stop, exp_sum);
    end
  endtask

  // One clock: drive, advance model at the edge, sample 1 time unit later.
  task automatic step(input logic r, input logic op, input logic [3:0] n,
                      input logic [15:0] cy, input string name);
    sl_res = r; sl_op = op; num = n; cypher = cy;
    @(posedge clock);
    model_edge(r, op, n, cy);
    #1;
    check({name, "/model"}, m_stop, 8'(m_sum));
  endtask

  initial begin
    sl_res = 1'b1; sl_op = 1'b0; num = 4'h0; cypher = 16'h0;
    m_sum = 0; m_stop = 1'b0;

    // Reset, then the reference session.
    add(1, 0, 4'h0, 16'h2601, 0, 8'h00, "reset");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd0,  "ref");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd1,  "ref");
    add(0, 1, 4'h3, 16'h2601, 0, 8'd4,  "ref");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd4,  "ref");
    add(0, 1, 4'h3, 16'h2601, 0, 8'd7,  "ref");
    add(0, 1, 4'h4, 16'h2601, 0, 8'd11, "ref");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd12, "ref");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd12, "ref");
    add(0, 1, 4'h2, 16'h2601, 0, 8'd14, "ref");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd15, "ref");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd16, "ref");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd16, "ref");
    add(0, 1, 4'h6, 16'h2601, 0, 8'd22, "ref");
    add(0, 1, 4'h2, 16'h2601, 1, 8'h18, "ref_match");
    // Near miss then correct entry.
    add(1, 1, 4'h7, 16'h2601, 0, 8'h00, "reset_op");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd1,  "near");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd1,  "near");
    add(0, 1, 4'h6, 16'h2601, 0, 8'd7,  "near");
    add(0, 1, 4'h3, 16'h2601, 0, 8'h0A, "near_miss");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd11, "near");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd11, "near");
    add(0, 1, 4'h6, 16'h2601, 0, 8'd17, "near");
    add(0, 1, 4'h2, 16'h2601, 1, 8'h13, "near_match");
    // Enable gating with gaps inside a correct sequence.
    add(1, 0, 4'h0, 16'h2601, 0, 8'h00, "reset");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd1,  "gate");
    add(0, 0, 4'h5, 16'h2601, 0, 8'd1,  "gate_hold");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd1,  "gate");
    add(0, 0, 4'h9, 16'h2601, 0, 8'd1,  "gate_hold");
    add(0, 1, 4'h6, 16'h2601, 0, 8'd7,  "gate");
    add(0, 0, 4'h2, 16'h2601, 0, 8'd7,  "gate_hold");
    add(0, 0, 4'h3, 16'h2601, 0, 8'd7,  "gate_hold");
    add(0, 1, 4'h2, 16'h2601, 1, 8'd9,  "gate_match");
    // Zero cypher count guard.
    add(1, 0, 4'h0, 16'h0000, 0, 8'h00, "reset");
    add(0, 1, 4'h0, 16'h0000, 0, 8'h00, "zero_guard");
    add(0, 1, 4'h0, 16'h0000, 0, 8'h00, "zero_guard");
    add(0, 1, 4'h0, 16'h0000, 0, 8'h00, "zero_guard");
    add(0, 1, 4'h0, 16'h0000, 1, 8'h00, "zero_match");
    // Reset mid-session discards the concurrent digit and all history.
    add(1, 0, 4'h0, 16'h2601, 0, 8'h00, "reset");
    add(0, 1, 4'h1, 16'h2601, 0, 8'd1,  "mid");
    add(0, 1, 4'h0, 16'h2601, 0, 8'd1,  "mid");
    add(0, 1, 4'h6, 16'h2601, 0, 8'd7,  "mid");
    add(1, 1, 4'h2, 16'h2601, 0, 8'h00, "mid_reset");
    add(0, 1, 4'h2, 16'h2601, 0, 8'h02, "mid_after");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].res, vecs[i].op, vecs[i].num, vecs[i].cy, vecs[i].name);
      check(vecs[i].name, vecs[i].exp_stop, vecs[i].exp_sum);
    end

    // After a match: 30 cycles of mixed enable and digits leave everything frozen.
    step(1'b1, 1'b0, 4'h0, 16'h2601, "reset");
    foreach (vecs[i]) begin
      if (i >= 1 && i <= 14) step(1'b0, 1'b1, vecs[i].num, 16'h2601, "ref2");
    end
    check("ref2_match", 1'b1, 8'h18);
    for (int i = 0; i < 30; i++) begin
      step(1'b0, 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), 16'h2601, "frozen");
      check("frozen", 1'b1, 8'h18);
    end

    // Sum wrap with a cypher that the digits never match.
    step(1'b1, 1'b0, 4'h0, 16'h0000, "reset");
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 4'hF, 16'h0000, "wrap");
    check("wrap_17", 1'b0, 8'hFF);
    step(1'b0, 1'b1, 4'hF, 16'h0000, "wrap");
    check("wrap_18", 1'b0, 8'h0E);

    // Randomized sessions over a small digit alphabet so matches do occur.
    for (int s = 0; s < 20; s++) begin
      logic [15:0] cy;
      cy = {4'($urandom_range(3, 0)), 4'($urandom_range(3, 0)),
            4'($urandom_range(3, 0)), 4'($urandom_range(3, 0))};
      step(1'b1, 1'b0, 4'h0, cy, "rand_reset");
      for (int c = 0; c < 150; c++) begin
        step(1'($urandom_range(99, 0) < 2),
             1'($urandom_range(3, 0) != 0),
             4'($urandom_range(3, 0)), cy, "rand");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
